fetch_aligner: RTL and testbench

//  Sits between the IF stage PC logic and the I-cache. Turns a halfword-aligned PC into
//  one aligned instruction (RV32IC). Fetches 32-bit words, byte-swaps them to normal

---
 rtl/fetch_aligner_pkg.sv | 23 ++
 rtl/fetch_aligner_word_buf.sv | 39 +++
 rtl/fetch_aligner.sv | 137 +++++++++++++
 tb/tb_fetch_aligner.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_aligner_pkg.sv
// Shared types and helpers for the RV32IC fetch aligner.
package fetch_aligner_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned WADDR_W = 30;
  localparam int unsigned HALF_W  = 16;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FETCH    = 2'd1,
    S_FETCH_HI = 2'd2
  } state_t;

  function automatic logic is_32bit(input logic [HALF_W-1:0] half);
    return half[1:0] == 2'b11;
  endfunction

  // Cache delivers byte 0 on [31:24]; put it back on [7:0].
  function automatic logic [XLEN-1:0] byte_swap(input logic [XLEN-1:0] rd);
    return {rd[7:0], rd[15:8], rd[23:16], rd[31:24]};
  endfunction

endpackage

// File: rtl/fetch_aligner_word_buf.sv
// One-word fetch buffer: tag/data/valid, byte-swap on fill, hit compares for A and A+1.
module fetch_aligner_word_buf
  import fetch_aligner_pkg::*;
#(
  parameter logic [WADDR_W-1:0] RESET_TAG = 30'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [WADDR_W-1:0] wr_tag,
  input  logic [XLEN-1:0]    wr_rdata,
  input  logic [WADDR_W-1:0] lookup_tag,
  output logic [XLEN-1:0]    word,
  output logic               hit,
  output logic               hit_next
);

  logic               valid;
  logic [WADDR_W-1:0] tag;
  logic [WADDR_W-1:0] lookup_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= RESET_TAG;
      word  <= '0;
    end else if (wr_en) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      word  <= byte_swap(wr_rdata);
    end
  end

  // A+1 wraps within the 30-bit word address space.
  assign lookup_next = WADDR_W'(lookup_tag + WADDR_W'(1));
  assign hit         = valid && (tag == lookup_tag);
  assign hit_next    = valid && (tag == lookup_next);

endmodule

// File: rtl/fetch_aligner.sv
// Halfword-aligned PC to aligned RV32IC instruction, with straddle stitching via a spill half.
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter logic [WADDR_W-1:0] RESET_TAG = 30'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [XLEN-1:0]    pc,
  input  logic               stall,
  input  logic               step,
  input  logic               flush,
  output logic               ready,
  output logic               compressed,
  output logic [XLEN-1:0]    inst,
  input  logic               ICACHE_stall,
  output logic               ICACHE_ren,
  output logic               ICACHE_wen,
  output logic [WADDR_W-1:0] ICACHE_addr,
  input  logic [XLEN-1:0]    ICACHE_rdata,
  output logic [XLEN-1:0]    ICACHE_wdata
);

  state_t               state;
  logic [WADDR_W-1:0]   a;
  logic [WADDR_W-1:0]   a_next;
  logic [XLEN-1:0]      buf_word;
  logic                 buf_hit;
  logic                 buf_hit_next;
  logic [HALF_W-1:0]    lower;
  logic [HALF_W-1:0]    upper;
  logic [HALF_W-1:0]    spill;
  logic [WADDR_W-1:0]   spill_tag;
  logic                 spill_valid;
  logic                 spill_hit;
  logic                 fill;
  logic                 unused_pc0;

  assign a          = pc[31:2];
  assign a_next     = WADDR_W'(a + WADDR_W'(1));
  assign lower      = buf_word[15:0];
  assign upper      = buf_word[31:16];
  assign spill_hit  = spill_valid && (spill_tag == a);
  assign fill       = (state != S_RUN) && ICACHE_ren && !ICACHE_stall;
  assign unused_pc0 = pc[0];

  assign ICACHE_wen   = 1'b0;
  assign ICACHE_wdata = '0;

  fetch_aligner_word_buf #(
    .RESET_TAG (RESET_TAG)
  ) u_word_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (fill),
    .wr_tag     (ICACHE_addr),
    .wr_rdata   (ICACHE_rdata),
    .lookup_tag (a),
    .word       (buf_word),
    .hit        (buf_hit),
    .hit_next   (buf_hit_next)
  );

  // Zero-cycle output select while running; nothing is presented during a fetch.
  always_comb begin
    ready      = 1'b0;
    compressed = 1'b0;
    inst       = '0;
    if (state == S_RUN) begin
      if (!pc[1]) begin
        if (buf_hit) begin
          ready = 1'b1;
          if (is_32bit(lower)) begin
            inst = buf_word;
          end else begin
            compressed = 1'b1;
            inst       = {16'h0, lower};
          end
        end
      end else if (buf_hit && !is_32bit(upper)) begin
        ready      = 1'b1;
        compressed = 1'b1;
        inst       = {16'h0, upper};
      end else if (spill_hit && buf_hit_next) begin
        ready = 1'b1;
        inst  = {lower, spill};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_RUN;
      ICACHE_ren  <= 1'b0;
      ICACHE_addr <= '0;
      spill       <= '0;
      spill_tag   <= '0;
      spill_valid <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (!stall && step && !flush && !ready) begin
            if (pc[1] && spill_hit) begin
              state       <= S_FETCH_HI;
              ICACHE_ren  <= 1'b1;
              ICACHE_addr <= a_next;
            end else if (pc[1] && buf_hit) begin
              // Upper half opens a 32-bit inst: keep it and go get the next word.
              spill       <= upper;
              spill_tag   <= a;
              spill_valid <= 1'b1;
              state       <= S_FETCH_HI;
              ICACHE_ren  <= 1'b1;
              ICACHE_addr <= a_next;
            end else begin
              state       <= S_FETCH;
              ICACHE_ren  <= 1'b1;
              ICACHE_addr <= a;
            end
          end
        end
        S_FETCH, S_FETCH_HI: begin
          if (!ICACHE_stall) begin
            state      <= S_RUN;
            ICACHE_ren <= 1'b0;
          end
        end
        default: begin
          state      <= S_RUN;
          ICACHE_ren <= 1'b0;
        end
      endcase
      if (flush || !step) spill_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Randomized scoreboard bench for fetch_aligner against a halfword-stream reference model.
module tb_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        stall, step, flush;
  logic        ready, compressed;
  logic [31:0] inst;
  logic        icache_stall;
  logic        icache_ren, icache_wen;
  logic [29:0] icache_addr;
  logic [31:0] icache_rdata, icache_wdata;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        comp;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          pops = 0;
  bit          run_checks = 1'b0;
  bit          force_cstall = 1'b0;
  logic [31:0] mem_lo[16];
  logic [31:0] mem_hi[16];

  always #5 clk = ~clk;

  fetch_aligner #(.RESET_TAG(30'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc           (pc),
    .stall        (stall),
    .step         (step),
    .flush        (flush),
    .ready        (ready),
    .compressed   (compressed),
    .inst         (inst),
    .ICACHE_stall (icache_stall),
    .ICACHE_ren   (icache_ren),
    .ICACHE_wen   (icache_wen),
    .ICACHE_addr  (icache_addr),
    .ICACHE_rdata (icache_rdata),
    .ICACHE_wdata (icache_wdata)
  );

  // Memory holds normalised words: halfword at byte +0 in [15:0].
  function automatic logic [31:0] word_at(input logic [29:0] wa);
    if (wa < 30'd16) return mem_lo[wa[3:0]];
    if (wa >= 30'h3FFF_FFF0) return mem_hi[wa[3:0]];
    return 32'h0;
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] byte_addr);
    logic [31:0] w;
    w = word_at(byte_addr[31:2]);
    return byte_addr[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic exp_t model(input logic [31:0] p);
    exp_t e;
    logic [15:0] h0, h1;
    h0 = half_at(p);
    h1 = half_at(32'(p + 32'd2));
    e.pc = p;
    if (h0[1:0] != 2'b11) begin
      e.comp = 1'b1;
      e.inst = {16'h0, h0};
    end else begin
      e.comp = 1'b0;
      e.inst = {h1, h0};
    end
    return e;
  endfunction

  function automatic logic [15:0] gen_half();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
    else if (h[1:0] == 2'b11) h[0] = 1'b0;
    return h;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [5:0] off;
    off = {5'($urandom_range(0, 31)), 1'b0};
    if ($urandom_range(0, 1) == 1) return 32'hFFFF_FFC0 | 32'(off);
    return 32'(off);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (pc=%h t=%0t)", name, act, expv, pc, $time);
    end
  endtask

  // Cache model: random busy cycles, read data presented from the registered address.
  initial begin
    icache_stall = 1'b0;
    icache_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      icache_stall = force_cstall || ($urandom_range(0, 2) == 0);
      icache_rdata = {word_at(icache_addr)[7:0], word_at(icache_addr)[15:8],
                      word_at(icache_addr)[23:16], word_at(icache_addr)[31:24]};
    end
  end

  // Monitor: protocol holds, stall stability, and scoreboard pops on ready.
  logic        last_ready;
  logic        last_comp;
  logic [31:0] last_inst, last_pc;
  logic        prev_rs;
  logic [29:0] prev_addr;

  always @(negedge clk) begin
    if (!run_checks || !rst_n) begin
      prev_rs    = 1'b0;
      last_ready = 1'b0;
    end else begin
      if (prev_rs) begin
        check("ren_held", 32'(icache_ren), 32'd1);
        check("addr_held", 32'(icache_addr), 32'(prev_addr));
      end
      prev_rs   = icache_ren && icache_stall;
      prev_addr = icache_addr;
      if (stall && last_ready && pc == last_pc) begin
        check("stall_ready", 32'(ready), 32'd1);
        check("stall_inst", inst, last_inst);
        check("stall_comp", 32'(compressed), 32'(last_comp));
        check("stall_ren", 32'(icache_ren), 32'd0);
      end else if (ready && !stall && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("inst", inst, e.inst);
        check("compressed", 32'(compressed), 32'(e.comp));
        pops++;
      end
      last_ready = ready;
      last_inst  = inst;
      last_comp  = compressed;
      last_pc    = pc;
    end
  end

  task automatic apply_pc(input logic [31:0] p);
    int  target;
    int  r;
    bit  done;
    @(posedge clk);
    #1;
    r      = int'($urandom_range(0, 5));
    pc     = p;
    step   = (r != 0);
    flush  = (r == 1);
    stall  = 1'b0;
    target = pops + 1;
    sb.push_back(model(p));
    done = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk);
      #1;
      step  = 1'b1;
      flush = 1'b0;
      if (pops >= target) begin
        done = 1'b1;
        break;
      end
      stall = ($urandom_range(0, 4) == 0);
    end
    stall = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: no ready for pc %h", p);
      sb.delete();
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    pc    = 32'h0;
    stall = 1'b0;
    step  = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_lo[i] = {gen_half(), gen_half()};
      mem_hi[i] = {gen_half(), gen_half()};
    end
    mem_lo[0]        = 32'h0001_4501;
    mem_hi[15][17:16] = 2'b11;

    do_reset(2);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_comp", 32'(compressed), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_ren", 32'(icache_ren), 32'd0);
    check("rst_addr", 32'(icache_addr), 32'd0);
    check("wen_tied", 32'(icache_wen), 32'd0);
    check("wdata_tied", icache_wdata, 32'd0);
    run_checks = 1'b1;

    apply_pc(32'h0000_0000);
    apply_pc(32'h0000_0002);
    apply_pc(32'hFFFF_FFFE);
    apply_pc(32'hFFFF_FFFC);
    for (int n = 0; n < 300; n++) apply_pc(rand_pc());

    // Reset while a read is outstanding: request must drop, then recover cleanly.
    run_checks = 1'b0;
    do_reset(1);
    force_cstall = 1'b1;
    pc = 32'h0000_0014;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (icache_ren) begin
        seen = 1'b1;
        break;
      end
    end
    check("midfetch_ren_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midfetch_ren_drop", 32'(icache_ren), 32'd0);
    check("midfetch_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    force_cstall = 1'b0;
    run_checks   = 1'b1;
    apply_pc(32'h0000_0014);
    apply_pc(32'h0000_0016);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
